// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the main-memory line-port arbiter.
//   arb_state_t  - arbiter FSM states (IDLE, ISSUE, DONE)
//   REQ_*        - requester index assignments
//   mem_line_t   - one memory line; LINE_OFF_W is the byte-offset width inside a line
package mem_arb_pkg;

  localparam int unsigned MEM_LINE_W = 128;
  localparam int unsigned LINE_OFF_W = 4;

  localparam int unsigned REQ_DCACHE = 0;
  localparam int unsigned REQ_SB     = 1;
  localparam int unsigned REQ_ICACHE = 2;

  typedef logic [MEM_LINE_W-1:0] mem_line_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } arb_state_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: per-requester saturating starvation counter.
// Ports:
//   clock, reset  - clock and asynchronous active-low reset
//   grant_evt     - an arbitration decision is made this cycle
//   granted       - this requester wins the current decision
//   pending       - this requester's req_valid
//   starved       - counter has reached STARVE_LIMIT
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic grant_evt,
  input  logic granted,
  input  logic pending,
  output logic starved
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_evt) begin
      if (granted || !pending) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_W'(STARVE_LIMIT)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved = (cnt_q == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises dcache, store-buffer and icache line transactions onto the
// single main-memory port, one transaction at a time (IDLE -> ISSUE -> DONE).
// Priority: starved requester (lowest index) > store buffer when sb_full > lowest index.
// Ports:
//   clock, reset                 - clock and asynchronous active-low reset
//   req_valid/we/addr/wdata      - per-requester line request, held until resp_valid
//   sb_full                      - promotes requester SB_IDX
//   gnt, resp_valid, resp_rdata  - owner one-hot, completion pulse, read line
//   mem_req/we/addr/wdata        - request to main memory, held until mem_ready
//   mem_ready, mem_rdata         - memory completion and read line (same cycle)
// Optional: define MEM_ARB_PERF_CNT_EN to add perf_grant_cnt / perf_wait_cnt outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_W       = 128,
  parameter int unsigned SB_IDX       = REQ_SB,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][LINE_W-1:0] req_wdata,
  input  logic                           sb_full,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [LINE_W-1:0]              resp_rdata,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [LINE_W-1:0]              mem_wdata,
  input  logic                           mem_ready,
  input  logic [LINE_W-1:0]              mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ-1:0][31:0]       perf_grant_cnt,
  output logic [NUM_REQ-1:0][31:0]       perf_wait_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [LINE_W-1:0]  resp_rdata_q, resp_rdata_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               grant_evt;
  logic               unused_addr_lsb;

  assign grant_evt = (state_q == IDLE) && (req_valid != '0);

  always_comb begin : win_sel
    logic found;
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && starved[i]) begin
        win_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
    if (!found && sb_full && req_valid[SB_IDX]) begin
      win_idx = IDX_W'(SB_IDX);
      found   = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        win_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

  assign win_oh = NUM_REQ'(1) << win_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ctr
    mem_arb_starve_ctr #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .CNT_W       (CNT_W)
    ) u_ctr (
      .clock    (clock),
      .reset    (reset),
      .grant_evt(grant_evt),
      .granted  (win_oh[i]),
      .pending  (req_valid[i]),
      .starved  (starved[i])
    );
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_evt) begin
          gnt_d       = win_oh;
          mem_req_d   = 1'b1;
          mem_we_d    = req_we[win_idx];
          mem_addr_d  = {req_addr[win_idx][ADDR_W-1:LINE_OFF_W], LINE_OFF_W'(0)};
          mem_wdata_d = req_wdata[win_idx];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          resp_rdata_d = mem_rdata;
          resp_valid_d = gnt_q;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign gnt        = gnt_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Line-offset bits are dropped from the memory address.
  always_comb begin
    unused_addr_lsb = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      unused_addr_lsb = unused_addr_lsb ^ (^req_addr[i][LINE_OFF_W-1:0]);
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [NUM_REQ-1:0][31:0] perf_grant_q, perf_grant_d;
  logic [NUM_REQ-1:0][31:0] perf_wait_q, perf_wait_d;

  always_comb begin
    perf_grant_d = perf_grant_q;
    perf_wait_d  = perf_wait_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_evt && win_oh[i]) perf_grant_d[i] = perf_grant_q[i] + 32'd1;
      if (req_valid[i] && !gnt_q[i]) perf_wait_d[i] = perf_wait_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_grant_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      perf_grant_q <= perf_grant_d;
      perf_wait_q  <= perf_wait_d;
    end
  end

  assign perf_grant_cnt = perf_grant_q;
  assign perf_wait_cnt  = perf_wait_q;
`endif

  // The owner must keep req_valid high until its response.
  owner_holds_req_a : assert property (@(posedge clock) disable iff (!reset)
    (state_q == ISSUE) |-> ((req_valid & gnt_q) != '0));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory line port between the dcache (fill/writeback), the store buffer drain and the icache refill.
- Sits in mem_stage between the requesters and main_memory. It serialises one 128-bit line transaction at a time through a req/ready handshake.
- Uses fixed priority, with a store-buffer-full promotion and a per-requester anti-starvation override.

Parameters:
- NUM_REQ, 3, number of requesters (0 = dcache, 1 = store buffer, 2 = icache).
- ADDR_W, 32, byte address width.
- LINE_W, 128, line data width.
- SB_IDX, 1, index of the store-buffer requester, promoted by sb_full.
- STARVE_LIMIT, 4, losing grants tolerated by a pending requester before it is forced to win.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request. Held high, fields stable, until that requester's resp_valid.
- req_we  in  NUM_REQ  1 = line write, 0 = line read.
- req_addr  in  NUM_REQ x ADDR_W  line address. Bits [3:0] are ignored.
- req_wdata  in  NUM_REQ x LINE_W  write line.
- sb_full  in  1  store buffer full; promotes SB_IDX.
- gnt  out  NUM_REQ  one-hot owner of the current transaction. Held from ISSUE through DONE.
- resp_valid  out  NUM_REQ  one-cycle completion pulse to the owner.
- resp_rdata  out  LINE_W  read line, valid with resp_valid. Undefined for writes.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  line-aligned address; low 4 bits forced to 0.
- mem_wdata  out  LINE_W  write data.
- mem_ready  in  1  memory accepted/completed the request this cycle. mem_rdata is valid in the same cycle.
- mem_rdata  in  LINE_W  read line.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - gnt, resp_valid, mem_req and mem_we are all 0; mem_addr, mem_wdata and resp_rdata are 0.
  - All starvation counters are 0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If any req_valid is set, pick a winner.
  - Register gnt, mem_addr, mem_we and mem_wdata from the winner, set mem_req = 1, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_req is held and the outputs are stable.
  - On mem_ready: capture mem_rdata into resp_rdata, drop mem_req, go to DONE.
  - No timeout.
- DONE:
  - resp_valid[owner] = 1 for exactly this cycle; gnt is cleared on exit. Return to IDLE.
  - The owner's req_valid is masked during DONE, so the owner may drop it the cycle after its response.
- Latency: request seen at cycle 0 → mem_req at cycle 1. mem_ready at cycle k → resp_valid at cycle k+1. Minimum 3 cycles between consecutive grants.
- Winner selection, highest rule first:
  1. Any pending requester with starve_cnt == STARVE_LIMIT; lowest index among them wins.
  2. SB_IDX, if sb_full and req_valid[SB_IDX] are both set.
  3. Lowest index with req_valid set.
- Starvation counter (per requester, saturating at STARVE_LIMIT):
  - Increments on each grant to another requester while its own req_valid is high.
  - Clears when it is granted or when its req_valid is low at a grant event.
- Boundary conditions:
  - Owner drops req_valid mid-transaction: the transaction completes and resp_valid still pulses. This is a protocol violation, checked by assertion.
  - Simultaneous requests: resolved in one cycle by the rules above.
  - sb_full asserted while another transaction is in flight: no preemption; the promotion applies at the next IDLE.
  - mem_ready while in IDLE or DONE: ignored.
  - Reset asserted mid-ISSUE: transaction abandoned and mem_req drops immediately. No response is issued.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds outputs:
  - perf_grant_cnt (NUM_REQ x 32): grants per requester.
  - perf_wait_cnt (NUM_REQ x 32): cycles with req_valid high and not owner.
  - Both wrap at 2^32 and reset to 0.
- When undefined, these ports and registers are absent; functional behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, DONE}.
  - Requester index constants REQ_DCACHE = 0, REQ_SB = 1, REQ_ICACHE = 2.
  - mem_line_t (LINE_W) and the line-offset width (4).
- Sub-module mem_arb_starve_ctr: one instance per requester. Holds the saturating counter and the starved flag.

Test Plan:
- Single dcache read of address 0x00, memory returns 0x...0005 after 3 cycles → mem_req at cycle 1, resp_valid[0] at cycle 5, resp_rdata[31:0] = 5.
- dcache, sb and icache request in the same cycle, sb_full = 0 → grant order 0, 1, 2. sb's resp_valid comes no earlier than 3 cycles after dcache's.
- Same three requests with sb_full = 1 → grant order 1, 0, 2.
- icache held pending while dcache re-requests continuously, STARVE_LIMIT = 4 → icache is granted on the 5th arbitration, and its counter returns to 0.
- Store-buffer write to address 0x14, wdata word0 = 16 → mem_addr = 0x10, mem_we = 1, mem_wdata[31:0] = 16, resp_valid[1] pulses once.
- Reset dropped during ISSUE → mem_req and gnt go to 0 asynchronously, no resp_valid. A new request after release completes normally.
